dmem_mmio_responder: RTL and testbench

DMEM_MMIO_RESPONDER -- requirements
Module: dmem_mmio_responder

---
 rtl/dmem_mmio_responder_if.sv | 25 ++
 rtl/dmem_mmio_responder.sv | 145 ++++++++++++++
 tb/tb_dmem_mmio_responder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_mmio_responder_if.sv
// CPU data-memory bus plus serial TX/RX byte streams for dmem_mmio_responder.
// The master side is the CPU and the serial environment; the slave side is the responder.
interface dmem_mmio_responder_if;
  logic [31:0] addr;
  logic [3:0]  wea;
  logic [31:0] wdata;
  logic        re;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  modport master (
    output addr, wea, wdata, re, tx_ready, rx_data, rx_valid,
    input  rdata, tx_data, tx_valid, rx_ready
  );

  modport slave (
    input  addr, wea, wdata, re, tx_ready, rx_data, rx_valid,
    output rdata, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/dmem_mmio_responder.sv
// Data RAM plus MMIO block (status, RX byte, TX FIFO, TX count, cycle counter).
// Define CYCLE_COUNTER_EN to build the 32-bit cycle counter at 0x8000_0010.
module dmem_mmio_responder #(
  parameter int unsigned MEM_AW     = 10,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_mmio_responder_if.slave  bus
);
  localparam int unsigned MEM_WORDS = 1 << MEM_AW;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;

  localparam logic [2:0] SEL_STATUS = 3'd0;
  localparam logic [2:0] SEL_RX     = 3'd1;
  localparam logic [2:0] SEL_TX     = 3'd2;
  localparam logic [2:0] SEL_TXCNT  = 3'd3;
  localparam logic [2:0] SEL_CYC    = 3'd4;

  logic [31:0]       mem [MEM_WORDS];
  logic [7:0]        tx_buf [FIFO_DEPTH];

  logic [31:0]       rdata_q, rdata_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic              tx_ovf_q, tx_ovf_d;
  logic              rx_full_q, rx_full_d;
  logic [7:0]        rx_byte_q, rx_byte_d;

  logic [MEM_AW-1:0] word_idx;
  logic [2:0]        sel;
  logic              is_mmio, rd_en, wr_en, ram_wr, mmio_wr;
  logic              tx_full, tx_push_req, tx_push, tx_pop, ovf_clr;
  logic              rx_take, rx_rd;
  logic [31:0]       rd_val, cyc_rd;
  logic              unused_addr;

  // Address decode; everything is gated off while rst is high
  assign is_mmio     = bus.addr[31];
  assign word_idx    = bus.addr[MEM_AW+1:2];
  assign sel         = bus.addr[4:2];
  assign rd_en       = bus.re && !rst;
  assign wr_en       = (|bus.wea) && !rst;
  assign ram_wr      = wr_en && !is_mmio;
  assign mmio_wr     = wr_en && is_mmio;
  assign unused_addr = ^{bus.addr[30:MEM_AW+2], bus.addr[1:0]};

  assign tx_full     = (tx_cnt_q == CNT_W'(FIFO_DEPTH));
  assign tx_push_req = mmio_wr && (sel == SEL_TX);
  assign tx_push     = tx_push_req && !tx_full;
  assign tx_pop      = (tx_cnt_q != '0) && bus.tx_ready && !rst;
  assign ovf_clr     = mmio_wr && (sel == SEL_STATUS);
  assign rx_take     = bus.rx_valid && !rx_full_q && !rst;
  assign rx_rd       = rd_en && is_mmio && (sel == SEL_RX);

`ifdef CYCLE_COUNTER_EN
  logic [31:0] cyc_q, cyc_d;
  logic        cyc_clr;

  assign cyc_clr = mmio_wr && (sel == SEL_CYC);
  assign cyc_d   = cyc_clr ? 32'd0 : cyc_q + 32'd1;
  assign cyc_rd  = cyc_q;

  always_ff @(posedge clk) begin
    if (rst) cyc_q <= '0;
    else     cyc_q <= cyc_d;
  end
`else
  assign cyc_rd = '0;
`endif

  // Byte-lane RAM writes and TX FIFO storage; neither is reset
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wea[b]) mem[word_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
    if (tx_push) tx_buf[wr_ptr_q] <= bus.wdata[7:0];
  end

  // Read mux samples pre-write state, giving read-first behaviour
  always_comb begin
    rd_val = '0;
    if (!is_mmio) begin
      rd_val = mem[word_idx];
    end else begin
      case (sel)
        SEL_STATUS: rd_val = {29'd0, tx_ovf_q, rx_full_q, !tx_full};
        SEL_RX:     rd_val = rx_full_q ? {24'd0, rx_byte_q} : 32'd0;
        SEL_TXCNT:  rd_val = 32'(tx_cnt_q);
        SEL_CYC:    rd_val = cyc_rd;
        default:    rd_val = '0;
      endcase
    end
  end

  always_comb begin
    rdata_d   = rdata_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    tx_ovf_d  = tx_ovf_q;
    rx_full_d = rx_full_q;
    rx_byte_d = rx_byte_q;
    tx_cnt_d  = tx_cnt_q + CNT_W'(tx_push) - CNT_W'(tx_pop);
    if (rd_en)   rdata_d  = rd_val;
    if (tx_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (tx_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    // Clearing overflow takes priority over a same-cycle dropped push
    if (ovf_clr)                     tx_ovf_d = 1'b0;
    else if (tx_push_req && tx_full) tx_ovf_d = 1'b1;
    if (rx_take) begin
      rx_full_d = 1'b1;
      rx_byte_d = bus.rx_data;
    end else if (rx_rd) begin
      rx_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tx_cnt_q  <= '0;
      tx_ovf_q  <= 1'b0;
      rx_full_q <= 1'b0;
      rx_byte_q <= '0;
    end else begin
      rdata_q   <= rdata_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_full_q <= rx_full_d;
      rx_byte_q <= rx_byte_d;
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.tx_data  = tx_buf[rd_ptr_q];
  assign bus.tx_valid = (tx_cnt_q != '0);
  assign bus.rx_ready = !rx_full_q;
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Scoreboard bench for dmem_mmio_responder: reads and TX pops are checked by monitors.
module tb_dmem_mmio_responder;
  localparam logic [31:0] A_STATUS = 32'h8000_0000;
  localparam logic [31:0] A_RX     = 32'h8000_0004;
  localparam logic [31:0] A_TX     = 32'h8000_0008;
  localparam logic [31:0] A_TXCNT  = 32'h8000_000C;
  localparam logic [31:0] A_CYC    = 32'h8000_0010;
`ifdef CYCLE_COUNTER_EN
  localparam logic [31:0] CYC_EXP = 32'd4;
`else
  localparam logic [31:0] CYC_EXP = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic re_seen = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] rd_exp_q [$];
  logic [7:0]  tx_exp_q [$];
  logic [31:0] last_rd = 32'd0;

  dmem_mmio_responder_if bus();

  dmem_mmio_responder #(.MEM_AW(10), .FIFO_DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Read monitor: rdata is due one cycle after an accepted read request
  always @(posedge clk) re_seen <= bus.re && !rst;

  always @(negedge clk) begin
    if (re_seen) begin
      if (rd_exp_q.size() == 0) begin
        chk("rdata_unexpected", bus.rdata, 32'hDEAD_BEEF);
      end else begin
        last_rd = rd_exp_q.pop_front();
        chk("rdata", bus.rdata, last_rd);
      end
    end
  end

  // TX monitor: every handshake must deliver the next expected byte
  always @(negedge clk) begin
    if (!rst && bus.tx_valid && bus.tx_ready) begin
      if (tx_exp_q.size() == 0) chk("tx_unexpected", 32'(bus.tx_data), 32'hDEAD_BEEF);
      else                      chk("tx_data", 32'(bus.tx_data), 32'(tx_exp_q.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                    input logic rd, input logic [31:0] exp);
    bus.addr  = a;
    bus.wea   = we;
    bus.wdata = wd;
    bus.re    = rd;
    if (rd) rd_exp_q.push_back(exp);
    step();
    bus.wea = 4'h0;
    bus.re  = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
    op(a, we, wd, 1'b0, 32'd0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp);
    op(a, 4'h0, 32'd0, 1'b1, exp);
  endtask

  task automatic drain_tx(input int budget);
    int left;
    left = budget;
    bus.tx_ready = 1'b1;
    while (tx_exp_q.size() != 0 && left > 0) begin
      step();
      left--;
    end
    bus.tx_ready = 1'b0;
    chk("tx_drain_left", 32'(tx_exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    bus.addr = '0; bus.wea = '0; bus.wdata = '0; bus.re = 1'b0;
    bus.tx_ready = 1'b0; bus.rx_data = '0; bus.rx_valid = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // Reset state and idle MMIO reads
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    rd(A_STATUS, 32'h1);
    rd(A_TXCNT, 32'd0);
    rd(A_RX, 32'd0);
    rd(32'h8000_0014, 32'd0);
    wr(32'h8000_0018, 4'hF, 32'h1234_5678);
    rd(32'h8000_0018, 32'd0);

    // Byte-lane write, read-first collision, rdata hold
    wr(32'h10, 4'hF, 32'hAABB_CCDD);
    wr(32'h10, 4'b0100, 32'h0011_0000);
    rd(32'h10, 32'hAA11_CCDD);
    op(32'h10, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'hAA11_CCDD);
    rd(32'h10, 32'hFFFF_FFFF);
    wr(32'h14, 4'b1001, 32'h1200_0034);
    wr(32'h14, 4'b0110, 32'h0056_7800);
    rd(32'h14, 32'h1256_7834);
    repeat (3) step();
    chk("rdata_hold", bus.rdata, 32'h1256_7834);

    // Overfill the TX FIFO, then drain in order
    for (int i = 1; i <= 9; i++) begin
      wr(A_TX, 4'h1, 32'(i));
      if (i <= 8) tx_exp_q.push_back(8'(i));
    end
    rd(A_TXCNT, 32'd8);
    rd(A_STATUS, 32'h4);
    drain_tx(20);
    chk("tx_valid_empty", 32'(bus.tx_valid), 32'd0);
    rd(A_STATUS, 32'h5);
    wr(A_STATUS, 4'h1, 32'd0);
    rd(A_STATUS, 32'h1);

    // Concurrent push/pop at count 3, then push-while-full with pop
    wr(A_TX, 4'h1, 32'h11); wr(A_TX, 4'h1, 32'h12); wr(A_TX, 4'h1, 32'h13);
    tx_exp_q.push_back(8'h11); tx_exp_q.push_back(8'h12); tx_exp_q.push_back(8'h13);
    bus.tx_ready = 1'b1;
    wr(A_TX, 4'h2, 32'h14);
    bus.tx_ready = 1'b0;
    tx_exp_q.push_back(8'h14);
    rd(A_TXCNT, 32'd3);
    for (int i = 'h15; i <= 'h19; i++) begin
      wr(A_TX, 4'h8, 32'(i));
      tx_exp_q.push_back(8'(i));
    end
    rd(A_TXCNT, 32'd8);
    bus.tx_ready = 1'b1;
    wr(A_TX, 4'h1, 32'h1A);
    bus.tx_ready = 1'b0;
    rd(A_TXCNT, 32'd7);
    rd(A_STATUS, 32'h5);
    wr(A_STATUS, 4'h4, 32'd0);
    drain_tx(20);
    rd(A_STATUS, 32'h1);

    // RX capture, read-clear, same-cycle arrival ignored
    bus.rx_valid = 1'b1; bus.rx_data = 8'h5A;
    step();
    bus.rx_valid = 1'b0;
    chk("rx_ready_full", 32'(bus.rx_ready), 32'd0);
    rd(A_STATUS, 32'h3);
    bus.rx_valid = 1'b1; bus.rx_data = 8'hA5;
    rd(A_RX, 32'h0000_005A);
    bus.rx_valid = 1'b0;
    chk("rx_ready_after_read", 32'(bus.rx_ready), 32'd1);
    rd(A_RX, 32'd0);

    // Cycle counter clear then read five cycles later
    wr(A_CYC, 4'hF, 32'd0);
    repeat (4) step();
    rd(A_CYC, CYC_EXP);

    // Reset with FIFO count 5 and RX full; RAM must survive
    wr(32'h40, 4'hF, 32'h1234_5678);
    for (int i = 0; i < 5; i++) wr(A_TX, 4'h1, 32'(8'hC0 + i));
    bus.rx_valid = 1'b1; bus.rx_data = 8'h77;
    step();
    bus.rx_valid = 1'b0;
    rd(A_TXCNT, 32'd5);
    chk("pre_rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    rst = 1'b1;
    bus.addr = 32'h40; bus.wea = 4'hF; bus.wdata = 32'hFFFF_FFFF; bus.re = 1'b1;
    bus.tx_ready = 1'b1;
    step();
    rst = 1'b0;
    bus.wea = 4'h0; bus.re = 1'b0; bus.tx_ready = 1'b0;
    chk("post_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("post_rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    chk("post_rst_rdata", bus.rdata, 32'd0);
    rd(32'h40, 32'h1234_5678);
    rd(A_TXCNT, 32'd0);
    rd(A_STATUS, 32'h1);

    step();
    chk("rd_queue_empty", 32'(rd_exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
